// File: rtl/register_file_scoreboard_if.sv
// Bus bundle for the register file: issue-side reads/reservations and the writeback port.
// The master drives indices, data and enables; the slave returns read data and busy status.
interface register_file_scoreboard_if #(
    parameter int N     = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic          writeEnable;
    logic [AW-1:0] rd;
    logic [N-1:0]  writerData;
    logic          reserveEnable;
    logic [AW-1:0] reserveRd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [N-1:0]  readData1;
    logic [N-1:0]  readData2;
    logic          rs1Busy;
    logic          rs2Busy;
    logic [AW:0]   busyCount;

    modport master (
        output writeEnable, rd, writerData, reserveEnable, reserveRd, rs1, rs2,
        input  readData1, readData2, rs1Busy, rs2Busy, busyCount
    );

    modport slave (
        input  writeEnable, rd, writerData, reserveEnable, reserveRd, rs1, rs2,
        output readData1, readData2, rs1Busy, rs2Busy, busyCount
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// Integer register file with write-to-read bypass and a per-register busy scoreboard.
// Issue reserves a destination, writeback writes it and releases the reservation.
module register_file_scoreboard #(
    parameter int N     = 64,
    parameter int NREGS = 32
) (
    input logic                        clk,
    input logic                        rst,
    register_file_scoreboard_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [N-1:0]     regs_q [NREGS];
    logic [N-1:0]     regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    logic write_valid;
    logic reserve_valid;
    logic count_inc;
    logic count_dec;
    logic rs1_hit;
    logic rs2_hit;

    assign write_valid   = bus.writeEnable && (bus.rd != '0);
    assign reserve_valid = bus.reserveEnable && (bus.reserveRd != '0);
    assign rs1_hit       = bus.writeEnable && (bus.rd == bus.rs1);
    assign rs2_hit       = bus.writeEnable && (bus.rd == bus.rs2);

    always_comb begin
        bus.readData1 = '0;
        bus.readData2 = '0;
        if (bus.rs1 != '0) begin
            bus.readData1 = rs1_hit ? bus.writerData : regs_q[bus.rs1];
        end
        if (bus.rs2 != '0) begin
            bus.readData2 = rs2_hit ? bus.writerData : regs_q[bus.rs2];
        end
        bus.rs1Busy   = busy_q[bus.rs1] && !rs1_hit && (bus.rs1 != '0);
        bus.rs2Busy   = busy_q[bus.rs2] && !rs2_hit && (bus.rs2 != '0);
        bus.busyCount = count_q;
    end

    // The reservation is applied after the release so a new producer wins on the same index.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (write_valid) begin
            regs_d[bus.rd] = bus.writerData;
            busy_d[bus.rd] = 1'b0;
        end
        if (reserve_valid) begin
            busy_d[bus.reserveRd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // Incremental count stays equal to popcount(busy) without a wide adder tree.
    always_comb begin
        count_inc = reserve_valid && !busy_q[bus.reserveRd];
        count_dec = write_valid && busy_q[bus.rd]
                    && !(reserve_valid && (bus.reserveRd == bus.rd));
        count_d   = count_q + (AW+1)'(count_inc) - (AW+1)'(count_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and
// randomized traffic checked against an array-based reference model.
module tb_register_file_scoreboard;
    localparam int N     = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    register_file_scoreboard_if #(.N(N), .NREGS(NREGS)) bus ();

    register_file_scoreboard #(.N(N), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [N-1:0]     m_regs [NREGS];
    logic [NREGS-1:0] m_busy;

    typedef struct {
        logic          v_rst;
        logic          we;
        logic [AW-1:0] rd;
        logic [N-1:0]  wd;
        logic          re;
        logic [AW-1:0] rrd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [N-1:0]  e_rd1;
        logic [N-1:0]  e_rd2;
        logic          e_b1;
        logic          e_b2;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [AW-1:0] rd, input logic [N-1:0] wd,
                                input logic re, input logic [AW-1:0] rrd,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic [N-1:0] e_rd1, input logic [N-1:0] e_rd2,
                                input logic e_b1, input logic e_b2, input logic [AW:0] e_cnt);
        vec_t v;
        v.v_rst = 1'b0;
        v.we = we;  v.rd = rd;  v.wd = wd;  v.re = re;  v.rrd = rrd;
        v.rs1 = rs1;  v.rs2 = rs2;
        v.e_rd1 = e_rd1;  v.e_rd2 = e_rd2;  v.e_b1 = e_b1;  v.e_b2 = e_b2;  v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic we, input logic [AW-1:0] rd,
                                  input logic [N-1:0] wd, input logic re, input logic [AW-1:0] rrd,
                                  input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        rst               = r;
        bus.writeEnable   = we;
        bus.rd            = rd;
        bus.writerData    = wd;
        bus.reserveEnable = re;
        bus.reserveRd     = rrd;
        bus.rs1           = rs1;
        bus.rs2           = rs2;
        #1;
    endtask

    // Reference model advances on the same edge as the DUT, from the architectural rules.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (bus.writeEnable && bus.rd != 0) begin
                m_regs[bus.rd] = bus.writerData;
                m_busy[bus.rd] = 1'b0;
            end
            if (bus.reserveEnable && bus.reserveRd != 0) m_busy[bus.reserveRd] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] model_read(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (bus.writeEnable && bus.rd == rs) return bus.writerData;
        return m_regs[rs];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] rs);
        return (rs != 0) && m_busy[rs] && !(bus.writeEnable && bus.rd == rs);
    endfunction

    task automatic check_output(input string tag);
        check_field({tag, " readData1"}, bus.readData1, model_read(bus.rs1));
        check_field({tag, " readData2"}, bus.readData2, model_read(bus.rs2));
        check_field({tag, " rs1Busy"}, N'(bus.rs1Busy), N'(model_busy(bus.rs1)));
        check_field({tag, " rs2Busy"}, N'(bus.rs2Busy), N'(model_busy(bus.rs2)));
        check_field({tag, " busyCount"}, N'(bus.busyCount), N'($countones(m_busy)));
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy = '0;

        // Directed table: outputs are sampled with the row's inputs applied, before the edge commits them.
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 5, 0,      0,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0,      1, 3, 3, 0, 0,      0,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 3, 0, 0,      0,      1, 0, 1));
        vecs.push_back(mk(1, 3, 64'hA1, 0, 0, 3, 0, 64'hA1, 0,      0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 0, 3, 0, 64'hA1, 0,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0,      1, 3, 3, 0, 64'hA1, 0,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 3, 0, 64'hA1, 0,      1, 0, 1));
        vecs.push_back(mk(1, 3, 64'hB2, 1, 3, 3, 0, 64'hB2, 0,      0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 0, 3, 0, 64'hB2, 0,      1, 0, 1));
        vecs.push_back(mk(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 3, 0,      64'hB2, 0, 1, 1));
        vecs.push_back(mk(1, 3, 64'h5,  0, 0, 0, 3, 0,      64'h5,  0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 0, 3, 3, 64'h5,  64'h5,  0, 0, 0));

        apply_stimulus(1, 1, 7, 64'h1234, 1, 9, 0, 5);
        tick();
        tick();

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].v_rst, vecs[k].we, vecs[k].rd, vecs[k].wd,
                           vecs[k].re, vecs[k].rrd, vecs[k].rs1, vecs[k].rs2);
            check_field($sformatf("vec%0d readData1", k), bus.readData1, vecs[k].e_rd1);
            check_field($sformatf("vec%0d readData2", k), bus.readData2, vecs[k].e_rd2);
            check_field($sformatf("vec%0d rs1Busy", k), N'(bus.rs1Busy), N'(vecs[k].e_b1));
            check_field($sformatf("vec%0d rs2Busy", k), N'(bus.rs2Busy), N'(vecs[k].e_b2));
            check_field($sformatf("vec%0d busyCount", k), N'(bus.busyCount), N'(vecs[k].e_cnt));
            tick();
        end

        // Fill the scoreboard completely, then drain it, checking the count every cycle.
        for (int i = 1; i < NREGS; i++) begin
            apply_stimulus(0, 0, 0, 0, 1, AW'(i), AW'(i), 0);
            check_output($sformatf("fill%0d", i));
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 31, 1);
        check_field("fill full count", N'(bus.busyCount), N'(31));
        for (int i = 1; i < NREGS; i++) begin
            apply_stimulus(0, 1, AW'(i), N'(i * 3), 0, 0, AW'(i), AW'(i == 31 ? 1 : i + 1));
            check_output($sformatf("drain%0d", i));
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 31, 1);
        check_field("drain empty count", N'(bus.busyCount), 0);

        // Reset must beat a concurrent write to a busy register.
        apply_stimulus(0, 1, 7, 64'hC7, 1, 7, 7, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 7, 0);
        check_output("pre-reset");
        apply_stimulus(1, 1, 7, 64'hDEAD, 0, 0, 7, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 7, 7);
        check_field("post-reset x7", bus.readData1, 0);
        check_field("post-reset busy", N'(bus.rs1Busy), 0);
        check_field("post-reset count", N'(bus.busyCount), 0);

        // Randomized traffic biased toward low indices so hazards collide often.
        for (int c = 0; c < 3000; c++) begin
            logic [AW-1:0] r_rd, r_rrd, r_rs1, r_rs2;
            r_rd  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r_rrd = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r_rs1 = ($urandom_range(0, 3) == 0) ? r_rd : AW'($urandom_range(0, 7));
            r_rs2 = ($urandom_range(0, 3) == 0) ? r_rrd : AW'($urandom);
            apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), r_rd,
                           {$urandom, $urandom}, ($urandom_range(0, 1) == 1), r_rrd, r_rs1, r_rs2);
            check_output($sformatf("rand%0d", c));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
